seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's N-digit common-anode 7-segment display.
- Holds a tear-free double-buffered display image.
- Steps one digit at a time at a prescaled rate, driving the active-low anode strobes and decimal point.
- Emits the 5-bit glyph code consumed by the hex-to-segment decoder: codes 0x0–0xF are hex glyphs; 0x10 is the special glyph.
- Sits between the MIPS memory-mapped IO write port and the decoder/pins.

Parameters:
N_DIGITS, 8, number of digits scanned (1..8)
PRESCALE, 100000, clk cycles per digit step (>=1); 100 MHz gives a 1 kHz digit rate

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
wr_en  in  1  load request; one-cycle strobe
wr_data  in  4*N_DIGITS  nibble i = hex value of digit i (digit 0 = rightmost)
wr_mask  in  N_DIGITS  1 = digit i displayed, 0 = digit off
wr_alt  in  N_DIGITS  1 = digit i shows special glyph code 0x10 instead of its nibble
wr_dp  in  N_DIGITS  1 = decimal point i lit
busy  out  1  pending image not yet committed
an  out  N_DIGITS  anode strobes, active-low, one-hot-low or all-high
digit  out  5  glyph code to decoder
dp  out  1  decimal point, active-low

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - pcnt=0, idx=0, busy=0.
  - Pending and active images (data/mask/alt/dp) all 0.
  - an = all 1s, digit = 5'h00, dp = 1.
- Reset mid-frame discards any pending image.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - tick = (pcnt==PRESCALE-1).
  - PRESCALE=1 gives tick every cycle.
- Scan index:
  - On tick, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
  - frame_end = tick && idx==N_DIGITS-1.
- Load handshake (latest wins):
  - wr_en=1: pending <= {wr_data, wr_mask, wr_alt, wr_dp}; busy <= 1.
  - wr_en while busy overwrites pending; no drop, no error.
- Commit: on frame_end with busy=1, active <= pending and busy <= 0 on the same edge.
  - wr_en coincident with frame_end: active takes the OLD pending, pending takes the new write, busy stays 1.
  - Commits happen only at frame boundaries, so a frame never mixes two images.
- Output stage (registered, 1-cycle latency from idx/active update):
  - an <= ~(onehot(idx) & {N{active_mask[idx]}}), so a masked digit gives an all-ones strobe.
  - digit <= active_alt[idx] ? 5'h10 : {1'b0, active_data[idx]}.
  - dp <= ~(active_dp[idx] & active_mask[idx]).
- Masked digits still occupy their scan slot (constant duty cycle per digit).
- Width rules: pcnt width = clog2(PRESCALE) (min 1); idx width = clog2(N_DIGITS) (min 1).
- N_DIGITS=1: idx is stuck at 0; frame_end == tick.

Optional Feature:
Macro SEG_SCAN_LZB_EN: leading-zero blanking.
- With macro:
  - Let m = highest index whose active nibble != 0 or whose alt bit = 1 (m=0 if none).
  - Digits with idx > m are treated as masked: an all 1s, dp 1.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - m is computed combinationally from the active image only and changes only at commit.
- Without macro: all masked-in digits are shown, including leading zeros.

Test Plan:
- Reset with PRESCALE=4, N=8: hold reset 3 cycles -> an=8'hFF, dp=1, digit=0, busy=0. Release -> idx advances every 4 clks; an stays 8'hFF (mask 0).
- wr_en with data=32'h1234ABCD, mask=8'hFF, alt=0, dp=8'h04 at mid-frame -> busy=1 until the first frame_end. Following frame shows:
  - idx0: an=8'hFE, digit=0xD.
  - idx2: an=8'hFB, digit=0xB, dp=0.
  - idx7: an=8'h7F, digit=0x1.
- Two wr_en pulses (32'h11111111, then 32'h22222222) within one frame -> next frame shows only 2s; busy falls exactly once.
- wr_en asserted on the frame_end cycle -> that frame commits the prior pending, busy remains 1, new image appears one frame later.
- mask=8'h0F, alt=8'h01 -> digit0 emits 5'h10; idx4..7 give an=8'hFF; dp=1.
- SEG_SCAN_LZB_EN defined, data=32'h00000050, mask=8'hFF -> only idx0 ("0") and idx1 ("5") strobe; data=0 -> only idx0 strobes.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Latency: an/digit/dp are registered, one cycle after the idx/active-image update.
// Backpressure: none; wr_en is always accepted, the latest write wins, and busy shows a pending image.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   wr_en                 - one-cycle load strobe for the pending image
//   wr_data/mask/alt/dp   - image: nibble per digit, enable, special-glyph select, decimal point
//   busy                  - pending image not yet committed to the active image
//   an                    - active-low anode strobes (one-hot-low or all-high)
//   digit                 - 5-bit glyph code to the decoder (0x10 = special glyph)
//   dp                    - active-low decimal point
//
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   wr_mask,
  input  logic [N_DIGITS-1:0]   wr_alt,
  input  logic [N_DIGITS-1:0]   wr_dp,
  output logic                  busy,
  output logic [N_DIGITS-1:0]   an,
  output logic [4:0]            digit,
  output logic                  dp
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  frame_end;

  logic [4*N_DIGITS-1:0] pend_data, act_data;
  logic [N_DIGITS-1:0]   pend_mask, act_mask;
  logic [N_DIGITS-1:0]   pend_alt,  act_alt;
  logic [N_DIGITS-1:0]   pend_dp,   act_dp;

  logic [3:0]            sel_nib;
  logic                  sel_mask;
  logic                  sel_alt;
  logic                  sel_dp;
  logic [N_DIGITS-1:0]   sel_oh;
  logic                  blank;
  logic                  show;

  assign tick      = (pcnt == PCNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  // Prescaler and scan index. With PRESCALE=1 pcnt stays 0 and tick is
  // constant; with N_DIGITS=1 idx stays 0 and frame_end equals tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  // Double buffer. Commit only at frame_end so one frame never mixes two
  // images. A write landing on the commit edge goes to pending while the old
  // pending moves to active, so busy stays set for one more frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data <= '0;
      pend_mask <= '0;
      pend_alt  <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_mask  <= '0;
      act_alt   <= '0;
      act_dp    <= '0;
      busy      <= 1'b0;
    end else begin
      if (frame_end && busy) begin
        act_data <= pend_data;
        act_mask <= pend_mask;
        act_alt  <= pend_alt;
        act_dp   <= pend_dp;
      end
      if (wr_en) begin
        pend_data <= wr_data;
        pend_mask <= wr_mask;
        pend_alt  <= wr_alt;
        pend_dp   <= wr_dp;
        busy      <= 1'b1;
      end else if (frame_end && busy) begin
        busy <= 1'b0;
      end
    end
  end

  // Select the active-image fields for the current scan slot.
  always_comb begin
    sel_nib  = 4'h0;
    sel_mask = 1'b0;
    sel_alt  = 1'b0;
    sel_dp   = 1'b0;
    sel_oh   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nib   = act_data[4*i +: 4];
        sel_mask  = act_mask[i];
        sel_alt   = act_alt[i];
        sel_dp    = act_dp[i];
        sel_oh[i] = 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Highest digit carrying a non-zero nibble or a special glyph; digits above
  // it are blanked. Digit 0 can never exceed lead, so "0" still shows.
  logic [IW-1:0] lead;

  always_comb begin
    lead = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if ((act_data[4*i +: 4] != 4'h0) || act_alt[i]) begin
        lead = IW'(i);
      end
    end
  end

  assign blank = (idx > lead);
`else
  assign blank = 1'b0;
`endif

  // Masked or blanked digits keep their slot but strobe nothing.
  assign show = sel_mask & ~blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      an    <= '1;
      digit <= 5'h00;
      dp    <= 1'b1;
    end else begin
      an    <= ~(sel_oh & {N_DIGITS{show}});
      digit <= sel_alt ? 5'h10 : {1'b0, sel_nib};
      dp    <= ~(sel_dp & show);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with PRESCALE=4, N_DIGITS=8: one scan slot is 4 clocks
// and one frame is 32 clocks. cyc counts non-reset clock edges, so a commit lands
// on edge 32*k and the registered outputs for slot i of that frame are
// visible after edge 32*k + 4*i + 1 .. 32*k + 4*i + 4.
module tb_seg_scan_ctrl;

  localparam int N  = 8;
  localparam int PS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [31:0]  wr_data;
  logic [7:0]   wr_mask, wr_alt, wr_dp;
  logic         busy;
  logic [7:0]   an;
  logic [4:0]   digit;
  logic         dp;

  seg_scan_ctrl #(.N_DIGITS(N), .PRESCALE(PS)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_mask (wr_mask),
    .wr_alt  (wr_alt),
    .wr_dp   (wr_dp),
    .busy    (busy),
    .an      (an),
    .digit   (digit),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int nid    = 0;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Scoreboard entry: en bit0 an, bit1 digit, bit2 dp, bit3 busy.
  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [7:0] an;
    logic [4:0] dg;
    logic       dp;
    logic       busy;
    int         id;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [7:0]  alt;
    logic [7:0]  dpv;
    int          idx;
    logic [7:0]  an;
    logic [4:0]  dg;
    logic        dp;
  } vec_t;

  localparam int NV = 14;
  vec_t tv [NV];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s#%0d at cyc %0d: got %h, want %h", nm, id, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] en, input logic [7:0] a,
                      input logic [4:0] d, input logic p, input logic b);
    exp_t e;
    e.cyc = c; e.en = en; e.an = a; e.dg = d; e.dp = p; e.busy = b; e.id = nid;
    nid++;
    sb.push_back(e);
  endtask

  // Pop and compare every expectation due at the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act, exp;
      e = sb.pop_front();
      act = {15'd0, (e.en[0] ? an : 8'h00), (e.en[1] ? digit : 5'h00),
             (e.en[2] ? dp : 1'b0), (e.en[3] ? busy : 1'b0), 2'b00};
      exp = {15'd0, (e.en[0] ? e.an : 8'h00), (e.en[1] ? e.dg : 5'h00),
             (e.en[2] ? e.dp : 1'b0), (e.en[3] ? e.busy : 1'b0), 2'b00};
      if (e.cyc < cyc) begin
        tests++;
        failed++;
        $display("FAIL sb_missed#%0d: due cyc %0d, seen at %0d", e.id, e.cyc, cyc);
      end else begin
        chk("sb", e.id, act, exp);
      end
    end
  end

  // Drive a one-cycle write so that it is sampled on edge w.
  task automatic do_write(input int w, input logic [31:0] d, input logic [7:0] m,
                          input logic [7:0] a, input logic [7:0] p);
    if (cyc > w - 1) begin
      tests++;
      failed++;
      $display("FAIL sched: write for cyc %0d issued at cyc %0d", w, cyc);
      return;
    end
    while (cyc < w - 1) @(negedge clk);
    wr_en = 1'b1; wr_data = d; wr_mask = m; wr_alt = a; wr_dp = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f, w, cc, guard;

    tv[0]  = '{32'h1234ABCD, 8'hFF, 8'h00, 8'h04, 0, 8'hFE, 5'h0D, 1'b1};
    tv[1]  = '{32'h1234ABCD, 8'hFF, 8'h00, 8'h04, 2, 8'hFB, 5'h0B, 1'b0};
    tv[2]  = '{32'h1234ABCD, 8'hFF, 8'h00, 8'h04, 7, 8'h7F, 5'h01, 1'b1};
    tv[3]  = '{32'h87654321, 8'h0F, 8'h01, 8'hF0, 0, 8'hFE, 5'h10, 1'b1};
    tv[4]  = '{32'h87654321, 8'h0F, 8'h01, 8'hF0, 3, 8'hF7, 5'h04, 1'b1};
    tv[5]  = '{32'h87654321, 8'h0F, 8'h01, 8'hF0, 4, 8'hFF, 5'h05, 1'b1};
    tv[6]  = '{32'h87654321, 8'h0F, 8'h01, 8'hF0, 7, 8'hFF, 5'h08, 1'b1};
    tv[7]  = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 0, 8'hFE, 5'h00, 1'b1};
    tv[8]  = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 1, 8'hFD, 5'h05, 1'b1};
`ifdef SEG_SCAN_LZB_EN
    tv[9]  = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 3, 8'hFF, 5'h00, 1'b1};
    tv[10] = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 6, 8'hFF, 5'h00, 1'b1};
    tv[12] = '{32'h00000000, 8'hFF, 8'h00, 8'h00, 4, 8'hFF, 5'h00, 1'b1};
`else
    tv[9]  = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 3, 8'hF7, 5'h00, 1'b0};
    tv[10] = '{32'h00000050, 8'hFF, 8'h00, 8'h08, 6, 8'hBF, 5'h00, 1'b1};
    tv[12] = '{32'h00000000, 8'hFF, 8'h00, 8'h00, 4, 8'hEF, 5'h00, 1'b1};
`endif
    tv[11] = '{32'h00000000, 8'hFF, 8'h00, 8'h00, 0, 8'hFE, 5'h00, 1'b1};
    tv[13] = '{32'h00000000, 8'hFF, 8'h01, 8'h00, 0, 8'hFE, 5'h10, 1'b1};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_mask = '0; wr_alt = '0; wr_dp = '0;

    // Reset state after three reset cycles.
    repeat (3) @(negedge clk);
    chk("rst_an",    0, 32'(an),    32'hFF);
    chk("rst_dp",    0, 32'(dp),    32'h1);
    chk("rst_digit", 0, 32'(digit), 32'h0);
    chk("rst_busy",  0, 32'(busy),  32'h0);
    reset = 1'b0;

    // Empty mask: nothing strobes while the scan runs.
    push(2,  4'hF, 8'hFF, 5'h00, 1'b1, 1'b0);
    push(9,  4'hF, 8'hFF, 5'h00, 1'b1, 1'b0);
    push(17, 4'hF, 8'hFF, 5'h00, 1'b1, 1'b0);

    // Table: write mid-frame F, expect busy until the commit at 32(F+1),
    // then check one slot of the new frame.
    for (int r = 0; r < NV; r++) begin
      f = 1 + 2 * r;
      w = 32 * f + 10;
      push(w,              4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
      push(32 * (f+1) - 1, 4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
      push(32 * (f+1) + 4 * tv[r].idx + 2, 4'hF, tv[r].an, tv[r].dg, tv[r].dp, 1'b0);
      do_write(w, tv[r].data, tv[r].mask, tv[r].alt, tv[r].dpv);
    end

    // Two writes in one frame: only the second image appears, busy falls once.
    f = 1 + 2 * NV;
    push(32 * f + 5,       4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
    push(32 * f + 31,      4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
    push(32 * (f+1),       4'h8, 8'h00, 5'h00, 1'b0, 1'b0);
    push(32 * (f+1) + 2,   4'hF, 8'hFE, 5'h02, 1'b1, 1'b0);
    push(32 * (f+1) + 22,  4'hF, 8'hDF, 5'h02, 1'b1, 1'b0);
    push(32 * (f+2) + 1,   4'h8, 8'h00, 5'h00, 1'b0, 1'b0);
    do_write(32 * f + 5,  32'h11111111, 8'hFF, 8'h00, 8'h00);
    do_write(32 * f + 15, 32'h22222222, 8'hFF, 8'h00, 8'h00);

    // Write sampled on the commit edge: old pending goes active, busy holds.
    f = f + 3;
    push(32 * f + 10,      4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
    push(32 * (f+1),       4'h8, 8'h00, 5'h00, 1'b0, 1'b1);
    push(32 * (f+1) + 2,   4'hF, 8'hFE, 5'h03, 1'b1, 1'b1);
    push(32 * (f+1) + 30,  4'hF, 8'h7F, 5'h03, 1'b1, 1'b1);
    push(32 * (f+2),       4'h8, 8'h00, 5'h00, 1'b0, 1'b0);
    push(32 * (f+2) + 2,   4'hF, 8'hFE, 5'h04, 1'b1, 1'b0);
    do_write(32 * f + 10,  32'h33333333, 8'hFF, 8'h00, 8'h00);
    do_write(32 * (f+1),   32'h44444444, 8'hFF, 8'h00, 8'h00);

    guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      failed++;
      $display("FAIL sb_unchecked#%0d: due cyc %0d, now %0d", e.id, e.cyc, cyc);
    end

    // Reset mid-frame discards the pending image.
    cc = cyc;
    w  = 32 * (cc / 32 + 1) + 8;
    do_write(w, 32'h55555555, 8'hFF, 8'h00, 8'hFF);
    chk("pend_busy", 0, 32'(busy), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy",  0, 32'(busy),  32'h0);
    chk("mid_rst_an",    0, 32'(an),    32'hFF);
    chk("mid_rst_dp",    0, 32'(dp),    32'h1);
    chk("mid_rst_digit", 0, 32'(digit), 32'h0);
    reset = 1'b0;
    while (cyc < 40) @(negedge clk);
    chk("post_rst_an",    0, 32'(an),    32'hFF);
    chk("post_rst_busy",  0, 32'(busy),  32'h0);
    chk("post_rst_digit", 0, 32'(digit), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
